// File: rtl/dispatch_buffer.sv
// rtl/dispatch_buffer.sv - circular FIFO of 4-wide dispatch packets between rename and the issue queue
//
// Purpose:
//   Buffers 4-slot dispatch packets from rename and presents the head packet
//   to the 4-in/1-out issue queue, one packet per cycle. A branch kill clears
//   every stored or incoming slot whose branch mask overlaps the kill mask.
//   Slots keep their entry position when killed, so a fully killed entry
//   still dequeues, as a bubble packet.
//
// Optional feature:
//   DISPATCH_BUF_BYPASS_EN - when defined, a packet offered to an empty buffer
//   in a cycle where the issue queue consumes passes straight through to the
//   outputs with zero latency and is not written into storage.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_inst1..i_inst4, i_valid packet offered by rename
//   o_ready                   buffer not full
//   o_inst1..o_inst4, o_valid head packet to the issue queue (zeros when idle)
//   i_en                      issue queue consumes the head packet this cycle
//   i_BrKill                  {enKill, BranchMask}
module dispatch_buffer #(
    parameter int DEPTH     = 4,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_TAG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH_I   = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH_I-1:0]   i_inst1,
    input  logic [WIDTH_I-1:0]   i_inst2,
    input  logic [WIDTH_I-1:0]   i_inst3,
    input  logic [WIDTH_I-1:0]   i_inst4,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [WIDTH_I-1:0]   o_inst1,
    output logic [WIDTH_I-1:0]   o_inst2,
    output logic [WIDTH_I-1:0]   o_inst3,
    output logic [WIDTH_I-1:0]   o_inst4,
    output logic                 o_valid,
    input  logic                 i_en,
    input  logic [WIDTH_BRM:0]   i_BrKill
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH_I-1:0] slot_q [DEPTH][4];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    logic               full;
    logic               empty;
    logic               bypass;
    logic               enq;
    logic               deq;
    logic               kill_en;
    logic [WIDTH_BRM-1:0] kill_mask;

    logic [WIDTH_I-1:0] in_raw  [4];
    logic [WIDTH_I-1:0] in_filt [4];
    logic [WIDTH_I-1:0] out_w   [4];

    // A word is killed when its branch mask overlaps the kill mask.
    function automatic logic kill_hit(input logic [WIDTH_I-1:0] w,
                                      input logic en,
                                      input logic [WIDTH_BRM-1:0] mask);
        return en && (|(w[WIDTH_I-8 -: WIDTH_BRM] & mask));
    endfunction

    assign kill_en   = i_BrKill[WIDTH_BRM];
    assign kill_mask = i_BrKill[WIDTH_BRM-1:0];

    // Flags come from the registered count only.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign o_ready = ~full;

`ifdef DISPATCH_BUF_BYPASS_EN
    assign bypass  = empty & i_valid & i_en;
`else
    assign bypass  = 1'b0;
`endif

    assign o_valid = ~empty | bypass;
    // A bypassed packet is consumed directly and never occupies an entry.
    assign enq     = i_valid & ~full & ~bypass;
    assign deq     = i_en & ~empty;

    always_comb begin
        in_raw[0] = i_inst1;
        in_raw[1] = i_inst2;
        in_raw[2] = i_inst3;
        in_raw[3] = i_inst4;
        for (int s = 0; s < 4; s++) begin
            in_filt[s] = kill_hit(in_raw[s], kill_en, kill_mask) ? '0 : in_raw[s];
        end
    end

    // Head words are combinational from storage, so in a kill cycle the issue
    // queue still sees the pre-kill words and applies the kill itself.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            out_w[s] = '0;
            if (bypass) begin
                out_w[s] = in_filt[s];
            end else if (!empty) begin
                out_w[s] = slot_q[head_q][s];
            end
        end
    end

    assign o_inst1 = out_w[0];
    assign o_inst2 = out_w[1];
    assign o_inst3 = out_w[2];
    assign o_inst4 = out_w[3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int s = 0; s < 4; s++) begin
                    slot_q[e][s] <= '0;
                end
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int s = 0; s < 4; s++) begin
                    if (enq && (tail_q == PTR_W'(e))) begin
                        slot_q[e][s] <= in_filt[s];
                    end else if (kill_hit(slot_q[e][s], kill_en, kill_mask)) begin
                        slot_q[e][s] <= '0;
                    end
                end
            end
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// tb/tb_dispatch_buffer.sv - scoreboard bench for dispatch_buffer
module tb_dispatch_buffer;

    localparam int WI = 33;
    typedef logic [3:0][WI-1:0] pkt_t;

    logic          i_clk;
    logic          i_rst_n;
    logic [WI-1:0] i_inst1, i_inst2, i_inst3, i_inst4;
    logic          i_valid;
    logic          o_ready;
    logic [WI-1:0] o_inst1, o_inst2, o_inst3, o_inst4;
    logic          o_valid;
    logic          i_en;
    logic [3:0]    i_BrKill;

    int   vectors = 0;
    int   fails   = 0;
    pkt_t exp_q [$];

    dispatch_buffer dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_inst1  (i_inst1),
        .i_inst2  (i_inst2),
        .i_inst3  (i_inst3),
        .i_inst4  (i_inst4),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_inst1  (o_inst1),
        .o_inst2  (o_inst2),
        .o_inst3  (o_inst3),
        .o_inst4  (o_inst4),
        .o_valid  (o_valid),
        .i_en     (i_en),
        .i_BrKill (i_BrKill)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [4*WI-1:0] act, input logic [4*WI-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WI-1:0] mk(input logic [6:0] op, input logic [2:0] m, input logic [22:0] low);
        return {op, m, low};
    endfunction

    function automatic pkt_t gen(input int p);
        pkt_t r;
        for (int s = 0; s < 4; s++) begin
            r[s] = mk(7'((p*4 + s) % 127 + 1), 3'b000, 23'(p*97 + s*13 + 1));
        end
        return r;
    endfunction

    task automatic drive(input pkt_t p, input logic v, input logic en);
        i_inst1 = p[0];
        i_inst2 = p[1];
        i_inst3 = p[2];
        i_inst4 = p[3];
        i_valid = v;
        i_en    = en;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: whenever the issue queue takes a packet, it must match the
    // oldest expected one; when nothing is presented, the words must be zero.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && i_en) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL deq_unexpected: got %h expected no packet",
                             {o_inst4, o_inst3, o_inst2, o_inst1});
                end else begin
                    chk("deq_packet", {o_inst4, o_inst3, o_inst2, o_inst1}, exp_q.pop_front());
                end
            end else if (!o_valid) begin
                chk("idle_zero", {o_inst4, o_inst3, o_inst2, o_inst1}, '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        pkt_t k, l, ke, le, b;
        i_rst_n  = 1'b0;
        i_BrKill = '0;
        drive('0, 1'b0, 1'b0);
        repeat (2) step();
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_out", {o_inst4, o_inst3, o_inst2, o_inst1}, 0);
        i_rst_n = 1'b1;

        // Three entries held, then an asynchronous reset mid-stream.
        for (int p = 0; p < 3; p++) begin
            drive(gen(p), 1'b1, 1'b0);
            step();
        end
        drive('0, 1'b0, 1'b0);
        #1;
        chk("held_valid", o_valid, 1);
        chk("held_ready", o_ready, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_out", {o_inst4, o_inst3, o_inst2, o_inst1}, 0);
        step();
        i_rst_n = 1'b1;

        // Packet A after release, visible next cycle.
        drive(gen(3), 1'b1, 1'b0);
        exp_q.push_back(gen(3));
        #1;
        chk("a_not_yet", o_valid, 0);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("a_valid", o_valid, 1);
        drive('0, 1'b0, 1'b1);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("a_drained", o_valid, 0);

        // Fill P0..P5 with i_en low: P4 and P5 rejected.
        for (int p = 0; p < 6; p++) begin
            drive(gen(10 + p), 1'b1, 1'b0);
            #1;
            chk("fill_ready", o_ready, (p < 4) ? 1 : 0);
            if (p < 4) exp_q.push_back(gen(10 + p));
            step();
        end
        for (int p = 0; p < 4; p++) begin
            drive('0, 1'b0, 1'b1);
            step();
        end
        drive('0, 1'b0, 1'b0);
        #1;
        chk("fill_drained_valid", o_valid, 0);
        chk("fill_drained_ready", o_ready, 1);

        // Full with simultaneous enqueue and dequeue.
        for (int p = 0; p < 4; p++) begin
            drive(gen(20 + p), 1'b1, 1'b0);
            exp_q.push_back(gen(20 + p));
            step();
        end
        drive(gen(24), 1'b1, 1'b1);
        #1;
        chk("full_ready", o_ready, 0);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("after_full_ready", o_ready, 1);
        chk("after_full_valid", o_valid, 1);
        for (int p = 0; p < 3; p++) begin
            drive('0, 1'b0, 1'b1);
            step();
        end
        drive('0, 1'b0, 1'b0);
        #1;
        chk("full_drained_valid", o_valid, 0);

        // Wrap-around streaming: ten packets, i_en every cycle.
        for (int p = 0; p < 10; p++) begin
            drive(gen(30 + p), 1'b1, 1'b1);
            exp_q.push_back(gen(30 + p));
            #1;
            chk("wrap_ready", o_ready, 1);
            step();
        end
        drive('0, 1'b0, 1'b1);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("wrap_empty", o_valid, 0);

        // Kill: stored masks 001/010/100/000, incoming 011/100/000/001, kill 010.
        k[0] = mk(7'h11, 3'b001, 23'h000101);
        k[1] = mk(7'h12, 3'b010, 23'h000202);
        k[2] = mk(7'h13, 3'b100, 23'h000303);
        k[3] = mk(7'h14, 3'b000, 23'h000404);
        l[0] = mk(7'h21, 3'b011, 23'h001111);
        l[1] = mk(7'h22, 3'b100, 23'h002222);
        l[2] = mk(7'h23, 3'b000, 23'h003333);
        l[3] = mk(7'h24, 3'b001, 23'h004444);
        ke = k;
        ke[1] = '0;
        le = l;
        le[0] = '0;
        drive(k, 1'b1, 1'b0);
        exp_q.push_back(ke);
        step();
        drive(l, 1'b1, 1'b0);
        i_BrKill = 4'b1010;
        exp_q.push_back(le);
        #1;
        chk("kill_prekill_word", o_inst2, k[1]);
        step();
        i_BrKill = '0;
        drive('0, 1'b0, 1'b0);
        #1;
        chk("kill_ready", o_ready, 1);
        chk("kill_valid", o_valid, 1);
        drive('0, 1'b0, 1'b1);
        step();
        #1;
        chk("kill_second_entry", o_valid, 1);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("kill_drained", o_valid, 0);

        // Bypass behaviour on an empty buffer with i_valid and i_en together.
        b = gen(60);
        drive(b, 1'b1, 1'b1);
        exp_q.push_back(b);
        #1;
`ifdef DISPATCH_BUF_BYPASS_EN
        chk("byp_valid", o_valid, 1);
        chk("byp_out", {o_inst4, o_inst3, o_inst2, o_inst1}, b);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("byp_count_zero", o_valid, 0);
`else
        chk("nobyp_valid", o_valid, 0);
        step();
        drive('0, 1'b0, 1'b1);
        #1;
        chk("nobyp_next_valid", o_valid, 1);
        chk("nobyp_next_out", {o_inst4, o_inst3, o_inst2, o_inst1}, b);
        step();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("nobyp_drained", o_valid, 0);
`endif
        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
